ventana_cruz: RTL and testbench
===============================

Name: ventana_cruz

Overview:
- Raster-order pixel streamer that builds the 5-pixel cross neighbourhood (center, up, down, left, right) for every pixel of a frame.
- Feeds the combinational max comparator of the dilation filter directly; its five outputs wire to the comparator's five 8-bit inputs.
- Uses a 2-line delay line, border masking and an end-of-frame flush, so exactly IMG_W*IMG_H windows come out per frame, in raster order.

Parameters:
- IMG_W, 256, pixels per row (>=3)
- IMG_H, 256, rows per frame (>=2)
- DATA_W, 8, bits per pixel

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- in_pix  in  DATA_W  input pixel, raster order
- in_valid  in  1  in_pix valid
- in_ready  out  1  block accepts in_pix this cycle
- out_c  out  DATA_W  window center
- out_up  out  DATA_W  pixel above center (0 on row 0)
- out_dn  out  DATA_W  pixel below center (0 on row IMG_H-1)
- out_l  out  DATA_W  pixel left of center (0 on col 0)
- out_r  out  DATA_W  pixel right of center (0 on col IMG_W-1)
- out_valid  out  1  window valid
- out_ready  in  1  consumer accepts window
- out_last  out  1  window is center (IMG_H-1, IMG_W-1)

Behaviour:
- One clock domain; reset is synchronous and active-high: rst sampled on rising clk.
- States: RUN (accept pixels) and FLUSH (inject IMG_W zero pixels after the last real pixel). Reset state is RUN.
- hold = out_valid && !out_ready.
- in_ready = (state==RUN) && !hold.
- step = !hold && ((state==RUN && in_valid) || state==FLUSH).
- On step, the shift value (in_pix in RUN, 0 in FLUSH) enters a delay line of 2*IMG_W entries (registers or line-buffer RAM).
- Taps relative to the newest entry:
  - dn = delay 0 (the value entering this step)
  - r = delay IMG_W-1
  - c = delay IMG_W
  - l = delay IMG_W+1
  - up = delay 2*IMG_W
- Step counter k counts steps from 0 to IMG_W*IMG_H+IMG_W-1. The center index for step k is k-IMG_W and is valid only when k >= IMG_W.
- Center counters ctr_row/ctr_col start at (0,0) and advance in raster order on each valid-center step.
- Output register: loaded on each step with k >= IMG_W.
  - Masked values: up=0 if ctr_row==0; dn=0 if ctr_row==IMG_H-1; l=0 if ctr_col==0; r=0 if ctr_col==IMG_W-1. Otherwise tap values.
  - out_valid=1 on load.
  - out_last=1 if center is (IMG_H-1, IMG_W-1).
- When a step occurs with k < IMG_W, out_valid=0.
- When no step occurs and out_ready=1, out_valid clears to 0. When hold=1, all outputs stay stable.
- Latency: the window for center (0,0) appears the cycle after the (IMG_W+1)th accepted pixel. In general, the window for pixel j is registered on the step that accepts pixel j+IMG_W.
- RUN->FLUSH: on the step that accepts input index IMG_W*IMG_H-1 (last pixel). In FLUSH, in_ready=0 and steps proceed whenever !hold.
- FLUSH->RUN: on the step with k == IMG_W*IMG_H+IMG_W-1, which is the step producing out_last. On this transition k, ctr_row, ctr_col and the input counters reset to 0, and the next frame begins immediately.
- Delay-line contents are never cleared. Stale data from a previous frame or a pre-reset partial frame never reaches the outputs, because all reads are covered by the border masking above.
- Reset values: out_c/out_up/out_dn/out_l/out_r = 0; out_valid = 0; out_last = 0; in_ready = 1 (from the cycle after reset, state RUN); all counters = 0.
- Reset mid-frame or mid-FLUSH aborts the frame: no further windows are emitted, and the next accepted pixel is treated as pixel (0,0).
- in_valid is ignored while in_ready=0. in_pix may change freely while in_valid=0.

Test Plan:
- IMG_W=4, IMG_H=3, pixels 1..12, in_valid and out_ready tied 1 -> first out_valid the cycle after pixel 5 is accepted; window (0,0): c=1, up=0, dn=5, l=0, r=2.
- Same stream -> window (1,1): c=6, up=2, dn=10, l=5, r=7. Window (1,3): c=8, up=4, dn=12, l=7, r=0 (not 9). Exactly 12 windows are emitted in raster order.
- Same stream -> last window c=12, up=8, dn=0, l=11, r=0 with out_last=1. in_ready=0 for exactly 4 flush steps, then returns to 1.
- out_ready toggled randomly, in_valid gapped -> no window lost or duplicated; outputs stable while hold=1; in_ready=0 whenever hold=1.
- Back-to-back frame with values 101..112 -> window (0,0): c=101, up=0, dn=105, l=0, r=102; no data from frame 1 leaks through.
- rst pulsed after 7 pixels, then full frame 1..12 -> out_valid=0 in the cycle after rst; windows identical to the first test.

Source files
------------

// File: rtl/ventana_cruz_if.sv
// ventana_cruz_if: pixel-in / cross-window-out stream bundle for the dilation front end.
interface ventana_cruz_if #(parameter int DATA_W = 8);
    logic [DATA_W-1:0] in_pix, out_c, out_up, out_dn, out_l, out_r;
    logic in_valid, in_ready, out_valid, out_ready, out_last;
    modport master (
        output in_pix, in_valid, out_ready,
        input  in_ready, out_c, out_up, out_dn, out_l, out_r, out_valid, out_last
    );
    modport slave (
        input  in_pix, in_valid, out_ready,
        output in_ready, out_c, out_up, out_dn, out_l, out_r, out_valid, out_last
    );
endinterface

// File: rtl/ventana_cruz.sv
// ventana_cruz: raster streamer producing the masked 5-pixel cross window for every pixel of a frame.
module ventana_cruz #(
    parameter int IMG_W  = 256,
    parameter int IMG_H  = 256,
    parameter int DATA_W = 8
) (
    input logic clk,
    input logic rst,
    ventana_cruz_if.slave bus
);
    localparam int KW = $clog2(IMG_W * IMG_H + IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);
    localparam logic [KW-1:0] K_C0      = KW'(IMG_W);
    localparam logic [KW-1:0] K_IN_LAST = KW'(IMG_W * IMG_H - 1);
    localparam logic [KW-1:0] K_END     = KW'(IMG_W * IMG_H + IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);

    typedef enum logic {RUN, FLUSH} state_t;

    state_t state;
    logic [KW-1:0] k;
    logic [RW-1:0] ctr_row;
    logic [CW-1:0] ctr_col;
    logic [DATA_W-1:0] dl [2*IMG_W];
    logic [DATA_W-1:0] sv;
    logic hold, step;

    assign hold = bus.out_valid && !bus.out_ready;
    assign bus.in_ready = state == RUN && !hold;
    assign step = !hold && (state == FLUSH || bus.in_valid);
    assign sv = state == RUN ? bus.in_pix : '0;

    // dl[i] holds the value shifted in i+1 steps ago; stale entries are always masked
    always_ff @(posedge clk) begin
        if (step) begin
            dl[0] <= sv;
            for (int i = 1; i < 2 * IMG_W; i++) dl[i] <= dl[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= RUN;
            k             <= '0;
            ctr_row       <= '0;
            ctr_col       <= '0;
            bus.out_c     <= '0;
            bus.out_up    <= '0;
            bus.out_dn    <= '0;
            bus.out_l     <= '0;
            bus.out_r     <= '0;
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
        end else if (step) begin
            if (k >= K_C0) begin
                bus.out_c     <= dl[IMG_W-1];
                bus.out_up    <= ctr_row == '0 ? '0 : dl[2*IMG_W-1];
                bus.out_dn    <= ctr_row == ROW_LAST ? '0 : sv;
                bus.out_l     <= ctr_col == '0 ? '0 : dl[IMG_W];
                bus.out_r     <= ctr_col == COL_LAST ? '0 : dl[IMG_W-2];
                bus.out_valid <= 1'b1;
                bus.out_last  <= ctr_row == ROW_LAST && ctr_col == COL_LAST;
                ctr_col       <= ctr_col == COL_LAST ? '0 : ctr_col + 1'b1;
                if (ctr_col == COL_LAST) ctr_row <= ctr_row + 1'b1;
            end else begin
                bus.out_valid <= 1'b0;
                bus.out_last  <= 1'b0;
            end
            if (state == RUN && k == K_IN_LAST) state <= FLUSH;
            // frame wrap overrides the counter advances above
            if (k == K_END) begin
                state   <= RUN;
                k       <= '0;
                ctr_row <= '0;
                ctr_col <= '0;
            end else begin
                k <= k + 1'b1;
            end
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ventana_cruz.sv
// tb_ventana_cruz: directed checks of the cross-window streamer on a 4x3 frame.
module tb_ventana_cruz;
    localparam int W = 4;
    localparam int H = 3;
    localparam int N = W * H;

    typedef struct packed {
        logic [7:0] c, up, dn, l, r;
        logic last;
    } win_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ventana_cruz_if #(.DATA_W(8)) bus ();
    ventana_cruz #(.IMG_W(W), .IMG_H(H), .DATA_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    win_t rx[$];
    int n_vec = 0;
    int n_bad = 0;
    bit rand_rdy = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // window expected for raster index j of a frame whose pixels are base, base+1, ...
    function automatic win_t model(input int base, input int j);
        int r = j / W;
        int c = j % W;
        win_t w;
        w.c    = 8'(base + j);
        w.up   = r == 0     ? 8'd0 : 8'(base + j - W);
        w.dn   = r == H - 1 ? 8'd0 : 8'(base + j + W);
        w.l    = c == 0     ? 8'd0 : 8'(base + j - 1);
        w.r    = c == W - 1 ? 8'd0 : 8'(base + j + 1);
        w.last = j == N - 1;
        return w;
    endfunction

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1 bus.out_ready = 1'($urandom_range(0, 1));
        end
    end

    win_t prev_w;
    bit prev_hold = 1'b0;
    always @(negedge clk) begin
        win_t cur;
        cur = {bus.out_c, bus.out_up, bus.out_dn, bus.out_l, bus.out_r, bus.out_last};
        if (!rst) begin
            if (prev_hold) chk("hold_stable", {bus.out_valid, cur}, {1'b1, prev_w});
            if (bus.out_valid && !bus.out_ready) chk("in_ready_in_hold", bus.in_ready, 0);
            if (bus.out_valid && bus.out_ready) rx.push_back(cur);
        end
        prev_hold = !rst && bus.out_valid && !bus.out_ready;
        prev_w = cur;
    end

    task automatic send(input int base, input int npix, input bit gaps);
        for (int j = 0; j < npix; j++) begin
            int t = 0;
            bit done = 1'b0;
            while (!done) begin
                bus.in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
                bus.in_pix = bus.in_valid ? 8'(base + j) : 8'($urandom);
                @(negedge clk);
                done = bus.in_valid && bus.in_ready;
                @(posedge clk);
                #1;
                if (++t > 200) begin
                    chk("in_timeout", t, 0);
                    bus.in_valid = 1'b0;
                    return;
                end
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_windows(input int n);
        int t = 0;
        while (rx.size() < n && t < 500) begin
            @(posedge clk);
            t++;
        end
        repeat (8) @(posedge clk);
        #1;
        chk("window_count", rx.size(), n);
    endtask

    task automatic check_frame(input string tag, input int base, input int off);
        for (int j = 0; j < N; j++) begin
            if (off + j < rx.size()) chk(tag, rx[off+j], model(base, j));
            else chk("missing_window", rx.size(), off + N);
        end
    endtask

    task automatic hand(input string tag, input int idx, input win_t e);
        if (idx < rx.size()) chk(tag, rx[idx], e);
        else chk("missing_window", rx.size(), idx + 1);
    endtask

    initial begin
        int z;
        bus.in_valid = 1'b0;
        bus.in_pix = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_state", {bus.in_ready, bus.out_valid, bus.out_last, bus.out_c, bus.out_up,
                            bus.out_dn, bus.out_l, bus.out_r}, {1'b1, 42'd0});

        for (int i = 0; i < N; i++) begin
            bus.in_pix = 8'(i + 1);
            bus.in_valid = 1'b1;
            @(posedge clk);
            #1;
            chk("latency_valid", bus.out_valid, i >= W);
        end
        bus.in_valid = 1'b0;
        z = 0;
        while (!bus.in_ready && z < 20) begin
            z++;
            @(posedge clk);
            #1;
        end
        chk("flush_len", z, W);
        chk("last_flag", {bus.out_valid, bus.out_last}, 2'b11);
        wait_windows(N);
        hand("win_0_0", 0, {8'd1, 8'd0, 8'd5, 8'd0, 8'd2, 1'b0});
        hand("win_1_1", 5, {8'd6, 8'd2, 8'd10, 8'd5, 8'd7, 1'b0});
        hand("win_1_3", 7, {8'd8, 8'd4, 8'd12, 8'd7, 8'd0, 1'b0});
        hand("win_last", 11, {8'd12, 8'd8, 8'd0, 8'd11, 8'd0, 1'b1});
        check_frame("frame1", 1, 0);

        rx.delete();
        rand_rdy = 1'b1;
        send(31, N, 1'b1);
        wait_windows(N);
        rand_rdy = 1'b0;
        @(posedge clk);
        #2 bus.out_ready = 1'b1;
        check_frame("gapped", 31, 0);

        rx.delete();
        send(1, N, 1'b0);
        send(101, N, 1'b0);
        wait_windows(2 * N);
        hand("b2b_0_0", N, {8'd101, 8'd0, 8'd105, 8'd0, 8'd102, 1'b0});
        check_frame("b2b_f1", 1, 0);
        check_frame("b2b_f2", 101, N);

        send(1, 7, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_clears", {bus.out_valid, bus.out_last, bus.in_ready}, 3'b001);
        rx.delete();
        send(1, N, 1'b0);
        wait_windows(N);
        hand("rst_win_0_0", 0, {8'd1, 8'd0, 8'd5, 8'd0, 8'd2, 1'b0});
        check_frame("after_rst", 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
